// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-edge detection, bit-timing enable (band_sig),
// mid-bit sampling on clk_bps, 8N1 LSB-first assembly, valid/framing-error strobes.
module uart_rx_ctrl #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 clk_bps,
   output logic                 band_sig,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic                 s1_q, s2_q, s3_q;
   logic                 fall;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 band_q, band_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   // Two-flop synchronizer plus history flop; reset high so release looks like idle line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= rx;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign fall = s3_q & ~s2_q;

   // State register together with the registered datapath and strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         band_q  <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         band_q  <= band_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic: edges only matter in IDLE, clk_bps only outside IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (fall) state_d = START;
         START: if (clk_bps) state_d = s2_q ? IDLE : DATA;
         DATA:  if (clk_bps && (cnt_q == LAST_BIT)) state_d = STOP;
         STOP:  if (clk_bps) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; strobes default low so they last one cycle
   always_comb begin
      shift_d = shift_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      band_d  = band_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall) band_d = 1'b1;
         end
         START: begin
            if (clk_bps) begin
               if (s2_q) begin
                  band_d = 1'b0;
               end else begin
                  cnt_d = '0;
               end
            end
         end
         DATA: begin
            if (clk_bps) begin
               shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
               if (cnt_q != LAST_BIT) cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (clk_bps) begin
               band_d = 1'b0;
               if (s2_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: band_d = 1'b0;
      endcase
   end

   assign band_sig  = band_q;
   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);

endmodule
